// File: rtl/biquad_csr_pkg.sv
// Shared definitions for the biquad filter CSR protocol: loader states, the commit
// index, the per-stage coefficient count and the data-word marker bit.
package biquad_csr_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StFetch,
    StAddr,
    StData,
    StGap,
    StCaddr,
    StCdata,
    StCgap,
    StDone
  } loader_state_e;

  localparam int unsigned CsrWidth      = 32;
  localparam int unsigned CoefsPerStage = 5;
  localparam int unsigned DataMarkerBit = 31;
  localparam logic [2:0]  CommitIdx     = 3'd7;

  // Address-phase word: stage in the upper bits, coefficient (or commit) index below.
  function automatic logic [CsrWidth-1:0] addr_word(input logic [28:0] stage,
                                                     input logic [2:0]  idx);
    return {stage, idx};
  endfunction

endpackage

// File: rtl/biquad_coef_loader.sv
// Streams biquad coefficients from an external synchronous memory into the filter CSR
// as address/data strobe pairs, then writes one commit (enable) word per stage.
module biquad_coef_loader
  import biquad_csr_pkg::*;
#(
  parameter int unsigned STAGES            = 2,
  parameter int unsigned COEFFICIENT_WIDTH = 25
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  input  logic                                      commitOnly,
  output logic                                      busy,
  output logic                                      done,
  output logic [$clog2(STAGES*CoefsPerStage)-1:0]   coefAddr,
  input  logic [COEFFICIENT_WIDTH-1:0]              coefData,
  output logic                                      csrStrobe,
  output logic [CsrWidth-1:0]                       GPIO_OUT
);

  localparam int unsigned AddrW  = $clog2(STAGES * CoefsPerStage);
  localparam int unsigned StageW = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam logic [StageW-1:0] LastStage = StageW'(STAGES - 1);
  localparam logic [2:0]        LastCoef  = 3'(CoefsPerStage - 1);

  loader_state_e        state_q, state_d;
  logic [StageW-1:0]    stage_q, stage_d;
  logic [2:0]           coef_q, coef_d;
  logic                 commit_only_q, commit_only_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 strobe_q, strobe_d;
  logic [CsrWidth-1:0]  gpio_q, gpio_d;
  logic [AddrW-1:0]     coef_addr_q, coef_addr_d;
  logic [CsrWidth-1:0]  data_word;

  always_comb begin
    data_word = '0;
    data_word[DataMarkerBit] = 1'b1;
    data_word[COEFFICIENT_WIDTH-1:0] = coefData;
  end

  always_comb begin
    state_d       = state_q;
    stage_d       = stage_q;
    coef_d        = coef_q;
    commit_only_d = commit_only_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          commit_only_d = commitOnly;
          stage_d       = '0;
          coef_d        = '0;
          state_d       = commitOnly ? StCaddr : StFetch;
        end
      end
      StFetch: state_d = StAddr;
      StAddr:  state_d = StData;
      StData:  state_d = StGap;
      StGap: begin
        if (coef_q == LastCoef) begin
          coef_d = '0;
          if (stage_q == LastStage) begin
            stage_d = '0;
            state_d = StCaddr;
          end else begin
            stage_d = stage_q + 1'b1;
            state_d = StFetch;
          end
        end else begin
          coef_d  = coef_q + 3'd1;
          state_d = StFetch;
        end
      end
      StCaddr: state_d = StCdata;
      StCdata: state_d = StCgap;
      StCgap: begin
        if (stage_q == LastStage) begin
          stage_d = '0;
          state_d = StDone;
        end else begin
          stage_d = stage_q + 1'b1;
          state_d = StCaddr;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so each registered output lines up with the
  // state it belongs to. The DATA word is taken straight from coefData during ADDR, which
  // is the cycle the memory presents the word fetched by the preceding FETCH address.
  always_comb begin
    busy_d      = !(state_d inside {StIdle, StDone});
    done_d      = (state_d == StDone);
    strobe_d    = 1'b0;
    gpio_d      = '0;
    coef_addr_d = coef_addr_q;

    unique case (state_d)
      StFetch: coef_addr_d = AddrW'(32'(stage_d) * CoefsPerStage + 32'(coef_d));
      StAddr: begin
        strobe_d = 1'b1;
        gpio_d   = addr_word(29'(stage_d), coef_d);
      end
      StData: begin
        strobe_d = 1'b1;
        gpio_d   = data_word;
      end
      StCaddr: begin
        strobe_d = 1'b1;
        gpio_d   = addr_word(29'(stage_d), CommitIdx);
      end
      StCdata: begin
        strobe_d = 1'b1;
        gpio_d   = CsrWidth'(1) << DataMarkerBit;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      stage_q       <= '0;
      coef_q        <= '0;
      commit_only_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      strobe_q      <= 1'b0;
      gpio_q        <= '0;
      coef_addr_q   <= '0;
    end else begin
      state_q       <= state_d;
      stage_q       <= stage_d;
      coef_q        <= coef_d;
      commit_only_q <= commit_only_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      strobe_q      <= strobe_d;
      gpio_q        <= gpio_d;
      coef_addr_q   <= coef_addr_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign csrStrobe = strobe_q;
  assign GPIO_OUT  = gpio_q;
  assign coefAddr  = coef_addr_q;

endmodule

// File: tb/tb_biquad_coef_loader.sv
// Scoreboard bench for biquad_coef_loader: stimulus pushes expected CSR words and
// sequence timing, a negedge monitor pops and compares.
module tb_biquad_coef_loader;

  localparam int STAGES = 2;
  localparam int CW     = 25;
  localparam int NCOEF  = STAGES * 5;

  typedef struct {
    int s;
    int d;
    int addr;
  } seq_t;

  logic              clk = 1'b0;
  logic              rst, start, commitOnly;
  logic              busy, done, csrStrobe;
  logic [3:0]        coefAddr;
  logic [CW-1:0]     coef_data;
  logic [31:0]       GPIO_OUT;

  logic [CW-1:0]     mem [16];
  logic [31:0]       exp_q [$];
  seq_t              seq_q [$];
  longint            cap [STAGES][5];
  int                cyc = 0;
  int                checks = 0;
  int                failures = 0;
  int                last_addr = 0;
  bit                mon_en = 1'b0;

  biquad_coef_loader #(
    .STAGES(STAGES),
    .COEFFICIENT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .commitOnly(commitOnly),
    .busy(busy),
    .done(done),
    .coefAddr(coefAddr),
    .coefData(coef_data),
    .csrStrobe(csrStrobe),
    .GPIO_OUT(GPIO_OUT)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) coef_data <= mem[coefAddr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int k);
    while (cyc < k) tick();
  endtask

  task automatic push_commit_words();
    for (int st = 0; st < STAGES; st++) begin
      exp_q.push_back(32'((st << 3) | 7));
      exp_q.push_back(32'h8000_0000);
    end
  endtask

  task automatic push_full(input int s);
    seq_q.push_back('{s, s + STAGES * 23 + 1, NCOEF - 1});
    for (int st = 0; st < STAGES; st++)
      for (int c = 0; c < 5; c++) begin
        exp_q.push_back(32'((st << 3) | c));
        exp_q.push_back(32'h8000_0000 | 32'(mem[st * 5 + c]));
      end
    push_commit_words();
    last_addr = NCOEF - 1;
  endtask

  task automatic push_commit(input int s);
    seq_q.push_back('{s, s + STAGES * 3 + 1, last_addr});
    push_commit_words();
  endtask

  // One sequence with stray start pulses while busy and always one in the DONE cycle.
  task automatic run_seq(input bit co);
    int s, d;
    repeat ($urandom_range(0, 3)) tick();
    s = cyc;
    commitOnly = co;
    start = 1'b1;
    if (co) push_commit(s);
    else push_full(s);
    d = s + (co ? STAGES * 3 : STAGES * 23) + 1;
    tick();
    commitOnly = 1'($urandom);
    while (cyc <= d) begin
      start = (cyc == d) || ($urandom_range(0, 5) == 0);
      tick();
    end
    start = 1'b0;
    commitOnly = 1'b0;
    tick();
  endtask

  task automatic rand_mem();
    for (int i = 0; i < 16; i++) mem[i] = CW'($urandom);
  endtask

  // Monitor: checks busy/done timing, CSR words, idle-zero bus and strobe pair length.
  always @(negedge clk) begin : monitor
    bit exp_busy, exp_done;
    logic [31:0] w;
    logic [31:0] last_aw;
    int run;
    if (mon_en) begin
      exp_busy = seq_q.size() > 0 && cyc > seq_q[0].s && cyc < seq_q[0].d;
      exp_done = seq_q.size() > 0 && cyc == seq_q[0].d;
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("done", 32'(done), 32'(exp_done));
      if (exp_done) begin
        chk("coef_addr_at_done", 32'(coefAddr), 32'(seq_q[0].addr));
        void'(seq_q.pop_front());
      end
      if (csrStrobe === 1'b1) begin
        run++;
        chk("strobe_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          w = exp_q.pop_front();
          chk("csr_word", GPIO_OUT, w);
        end
        if (GPIO_OUT[31] == 1'b0) last_aw = GPIO_OUT;
        else if (last_aw[2:0] != 3'd7 && int'(last_aw >> 3) < STAGES)
          cap[int'(last_aw >> 3)][int'(last_aw[2:0]) % 5] = longint'($signed(GPIO_OUT[CW-1:0]));
      end else begin
        chk("gpio_idle_zero", GPIO_OUT, 32'd0);
        if (run != 0) begin
          chk("strobe_run_len", 32'(run), 32'd2);
          run = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int s;
    longint v, acc;
    longint x1 [STAGES], x2 [STAGES], y1 [STAGES], y2 [STAGES];
    rst = 1'b1;
    start = 1'b0;
    commitOnly = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = CW'(i + 1);
    tick();
    mon_en = 1'b1;
    tick();
    rst = 1'b0;
    chk("reset_coef_addr", 32'(coefAddr), 32'd0);
    chk("reset_strobe", 32'(csrStrobe), 32'd0);
    tick();

    // Directed full load of 1..10, then commit-only
    run_seq(1'b0);
    run_seq(1'b1);

    // Negative coefficient in slot 3
    rand_mem();
    mem[3] = '1;
    run_seq(1'b0);

    // start held for 60 cycles: second sequence accepted 48 cycles after the first
    s = cyc;
    start = 1'b1;
    push_full(s);
    push_full(s + 48);
    wait_until(s + 60);
    start = 1'b0;
    wait_until(s + 100);

    // Reset mid-sequence at cycle 20
    rand_mem();
    s = cyc;
    start = 1'b1;
    push_full(s);
    tick();
    start = 1'b0;
    wait_until(s + 20);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    seq_q.delete();
    exp_q.delete();
    last_addr = 0;
    chk("rst_abort_strobe", 32'(csrStrobe), 32'd0);
    chk("rst_abort_gpio", GPIO_OUT, 32'd0);
    chk("rst_abort_addr", 32'(coefAddr), 32'd0);
    repeat (30) tick();

    // rst and start together: rst wins
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    chk("rst_start_busy", 32'(busy), 32'd0);
    repeat (3) tick();
    run_seq(1'b1);
    run_seq(1'b0);

    // Unity-gain load, then drive a behavioural biquad with the captured coefficients
    for (int i = 0; i < 16; i++) mem[i] = '0;
    for (int st = 0; st < STAGES; st++) mem[st * 5] = CW'(1 << 23);
    run_seq(1'b0);
    for (int st = 0; st < STAGES; st++) begin
      x1[st] = 0; x2[st] = 0; y1[st] = 0; y2[st] = 0;
    end
    v = 0;
    for (int n = 0; n < 20; n++) begin
      v = 1000000;
      for (int st = 0; st < STAGES; st++) begin
        acc = cap[st][0] * v + cap[st][1] * x1[st] + cap[st][2] * x2[st]
            + cap[st][3] * y2[st] + cap[st][4] * y1[st];
        x2[st] = x1[st];
        x1[st] = v;
        y2[st] = y1[st];
        y1[st] = acc >>> 23;
        v = y1[st];
      end
    end
    chk("filter_step", 32'(v), 32'd1000000);

    // Random loads
    for (int k = 0; k < 4; k++) begin
      rand_mem();
      run_seq(1'($urandom));
    end

    repeat (5) tick();
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("seq_q_drained", 32'(seq_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/biquad_coef_loader.md
BIQUAD_COEF_LOADER -- requirements
Module: biquad_coef_loader

Interface
REQ-001 The block SHALL have parameter STAGES, default 2, giving the number of biquad stages in the target filter.
REQ-002 The block SHALL have parameter COEFFICIENT_WIDTH, default 25, giving the signed coefficient width.
REQ-003 The block SHALL have port clk  input  1  the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port start  input  1  a single-cycle load request.
REQ-006 The block SHALL have port commitOnly  input  1  sampled with start; 1 skips the coefficient writes and issues only the enable writes.
REQ-007 The block SHALL have port busy  output  1  high while a sequence is in progress.
REQ-008 The block SHALL have port done  output  1  a one-cycle pulse at the end of a sequence.
REQ-009 The block SHALL have port coefAddr  output  clog2(STAGES*5)  the coefficient memory address, equal to stage*5+coefIndex.
REQ-010 The block SHALL have port coefData  input  COEFFICIENT_WIDTH  memory read data, valid one cycle after coefAddr.
REQ-011 The block SHALL have port csrStrobe  output  1  the filter CSR strobe.
REQ-012 The block SHALL have port GPIO_OUT  output  32  the filter CSR word.

Function
REQ-013 The FSM SHALL have states IDLE, FETCH, ADDR, DATA, GAP, CADDR, CDATA, CGAP and DONE.
REQ-014 In IDLE, start=1 SHALL latch commitOnly and move to FETCH, or to CADDR if commitOnly=1, with the stage counter and coefficient counter both cleared to 0.
REQ-015 In FETCH, coefAddr SHALL equal stage*5+coef and csrStrobe SHALL be 0.
REQ-016 In ADDR, the block SHALL drive csrStrobe=1 and GPIO_OUT={stage[28:0], coef[2:0]}, and SHALL register coefData.
REQ-017 In DATA, the block SHALL hold csrStrobe=1 and drive GPIO_OUT={1'b1, (31-COEFFICIENT_WIDTH) zeros, registered coefficient}.
REQ-018 In GAP, the block SHALL drive csrStrobe=0 and GPIO_OUT=0, then advance coef 0..4; after coef 4 it SHALL advance stage; after the last stage it SHALL go to CADDR with stage=0, otherwise to FETCH.
REQ-019 The coefficient index order SHALL be 0..4 (b0, b1, b2, -a2, -a1); the memory already holds the values in that order and sign, and the block SHALL NOT perform arithmetic on them.
REQ-020 In CADDR the block SHALL drive csrStrobe=1 and GPIO_OUT={stage, 3'd7}; in CDATA csrStrobe=1 and GPIO_OUT=32'h8000_0000; in CGAP csrStrobe=0 and GPIO_OUT=0.
REQ-021 After CGAP for the last stage the FSM SHALL go to DONE; otherwise it SHALL increment stage and go to CADDR.
REQ-022 DONE SHALL last exactly one cycle with done=1 and busy=0, then go to IDLE.
REQ-023 busy SHALL be 1 in every state except IDLE and DONE.
REQ-024 A full sequence SHALL take STAGES*23 cycles from the start cycle to done (20 coefficient cycles plus 3 commit cycles per stage); for STAGES=2 this is 46 cycles, with done on cycle 47.
REQ-025 A commitOnly sequence SHALL take STAGES*3 cycles; for STAGES=2, done SHALL assert 7 cycles after start.
REQ-026 start SHALL be ignored while busy=1 and in DONE; it SHALL NOT be queued.
REQ-027 A start arriving in the cycle after DONE SHALL be accepted normally.
REQ-028 csrStrobe SHALL be high for exactly 2 consecutive cycles per CSR write and low for at least 1 cycle between writes.
REQ-029 Outside the strobe window, GPIO_OUT SHALL be 0 and SHALL never carry X.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 rst=1 SHALL force, at the next clock edge, state=IDLE, busy=0, done=0, csrStrobe=0, GPIO_OUT=0, coefAddr=0, and clear both counters.
REQ-032 rst asserted mid-sequence SHALL abort the sequence with no done pulse; the filter is left partially configured, and recovery is by a new start.
REQ-033 If rst and start are asserted in the same cycle, rst SHALL win.

Structure
REQ-034 The state encoding, the commit index 3'd7, the per-stage coefficient count 5 and the data-word marker bit 31 SHALL live in a shared package, biquad_csr_pkg, which the filter CSR decoder also uses.
REQ-035 The block SHALL be a single module with no sub-module; the coefficient memory SHALL stay external.

Verification
REQ-036 Full load: memory holds values 1..10 and start is pulsed -> 10 strobe pairs with address words 0..4 and 8..12, data words 0x80000001..0x8000000A, then commit words 0x00000007 and 0x0000000F, and done at cycle 47.
REQ-037 commitOnly: start with commitOnly=1 -> no coefAddr change, exactly two commit writes, and done at cycle 7.
REQ-038 Negative coefficient: memory[3]=-1 -> data word 0x81FF_FFFF.
REQ-039 start held high for 60 cycles -> one sequence, then a second sequence starting on cycle 48.
REQ-040 rst asserted at cycle 20 -> csrStrobe=0 and GPIO_OUT=0 at cycle 21, no done pulse, and a subsequent start completes normally.
REQ-041 Driving the real filter: load the unity-gain set (b0=2^23, all others 0) and apply a 1000000 step -> filter output equals 1000000 within 20 input samples.
